// File: rtl/osecpu_run_ctrl_pkg.sv
// Shared definitions for the OSECPU run controller: run-state encodings and CR bit positions.
package osecpu_run_ctrl_pkg;

    localparam int unsigned BIT_CR_HLT = 0;

    typedef enum logic [1:0] {
        RC_IDLE = 2'd0,
        RC_RST  = 2'd1,
        RC_RUN  = 2'd2,
        RC_FIN  = 2'd3
    } rc_state_t;

    function automatic logic is_halted(input logic [7:0] cr);
        return cr[BIT_CR_HLT];
    endfunction

endpackage

// File: rtl/osecpu_run_ctrl_if.sv
// Host handshake and core-status bundle between the run controller and its surroundings.
interface osecpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             stop;
    logic [7:0]       cpu_cr;
    logic [31:0]      cpu_dr;
    logic [15:0]      cpu_pc;
    logic             cpu_reset;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [31:0]      result;
    logic [15:0]      halt_pc;
    logic [CNT_W-1:0] cycles;

    modport slave (
        input  start, stop, cpu_cr, cpu_dr, cpu_pc,
        output cpu_reset, busy, done, timeout, result, halt_pc, cycles
    );

    modport master (
        output start, stop, cpu_cr, cpu_dr, cpu_pc,
        input  cpu_reset, busy, done, timeout, result, halt_pc, cycles
    );
endinterface

// File: rtl/osecpu_cycle_counter.sv
// Saturating RUN-cycle counter with synchronous clear and a terminal-count match at MAX_CYCLES-1.
module osecpu_cycle_counter #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT);
endmodule

// File: rtl/osecpu_run_ctrl.sv
// OSECPU run/sequence controller: reset, run, halt capture and cycle counting.
// Watchdog abort is compiled in only when RUNCTRL_WDT_EN is defined.
module osecpu_run_ctrl
    import osecpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned CNT_W        = 32
) (
    input logic               clk,
    input logic               reset,
    osecpu_run_ctrl_if.slave  bus
);
    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    rc_state_t        state;
    logic [RST_W-1:0] rst_cnt;
    logic             halt_hit;
    logic             wdt_hit;
    logic             at_limit;
    logic             launch;
    logic             run_exit;
    logic             unused_cr;

    assign halt_hit  = is_halted(bus.cpu_cr);
    assign unused_cr = ^bus.cpu_cr;

`ifdef RUNCTRL_WDT_EN
    assign wdt_hit = at_limit;
`else
    logic unused_limit;
    assign wdt_hit      = 1'b0;
    assign unused_limit = at_limit;
`endif

    assign launch   = ((state == RC_IDLE) || (state == RC_FIN)) && bus.start;
    assign run_exit = (state == RC_RUN) && (bus.stop || halt_hit || wdt_hit);

    // The counter freezes on the exit edge, so a watchdog abort reports MAX_CYCLES-1.
    osecpu_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (launch),
        .enable   ((state == RC_RUN) && !run_exit),
        .count    (bus.cycles),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RC_IDLE;
            rst_cnt       <= '0;
            bus.cpu_reset <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.result    <= '0;
            bus.halt_pc   <= '0;
        end else begin
            case (state)
                RC_IDLE, RC_FIN: begin
                    if (bus.start) begin
                        state       <= RC_RST;
                        bus.busy    <= 1'b1;
                        bus.done    <= 1'b0;
                        bus.timeout <= 1'b0;
                        rst_cnt     <= RST_W'(RESET_CYCLES - 1);
                    end else if (bus.stop) begin
                        state       <= RC_IDLE;
                        bus.done    <= 1'b0;
                        bus.timeout <= 1'b0;
                    end
                end
                RC_RST: begin
                    if (bus.stop) begin
                        state    <= RC_IDLE;
                        bus.busy <= 1'b0;
                    end else if (rst_cnt == '0) begin
                        state         <= RC_RUN;
                        bus.cpu_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                RC_RUN: begin
                    if (bus.stop) begin
                        state         <= RC_IDLE;
                        bus.cpu_reset <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b0;
                        bus.timeout   <= 1'b0;
                    end else if (halt_hit) begin
                        state         <= RC_FIN;
                        bus.cpu_reset <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.result    <= bus.cpu_dr;
                        bus.halt_pc   <= bus.cpu_pc;
                    end else if (wdt_hit) begin
                        state         <= RC_FIN;
                        bus.cpu_reset <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.timeout   <= 1'b1;
                        bus.result    <= bus.cpu_dr;
                        bus.halt_pc   <= bus.cpu_pc;
                    end
                end
                default: state <= RC_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_osecpu_run_ctrl.sv
// Directed, table-driven bench for osecpu_run_ctrl (watchdog expectations follow RUNCTRL_WDT_EN).
module tb_osecpu_run_ctrl;
    import osecpu_run_ctrl_pkg::*;

    localparam int unsigned RESET_CYCLES = 4;
    localparam int unsigned MAX_CYCLES   = 1000;
    localparam int unsigned CNT_W        = 32;
    localparam logic [7:0]  HLT_MASK     = 8'(1 << BIT_CR_HLT);
    localparam int          RUN_LIMIT    = 5100;

`ifdef RUNCTRL_WDT_EN
    localparam logic [31:0] PREV_R = 32'h0000_03E8;
    localparam logic [15:0] PREV_P = 16'h03E8;
`else
    localparam logic [31:0] PREV_R = 32'h1234_5678;
    localparam logic [15:0] PREV_P = 16'hBEEF;
`endif

    typedef struct {
        int          halt_after;
        int          stop_at;
        int          start_at;
        logic [31:0] dr;
        logic [15:0] pc;
        int          exp_exit;
        logic        exp_done;
        logic        exp_timeout;
        logic [31:0] exp_result;
        logic [15:0] exp_pc;
        logic [31:0] exp_cycles;
    } rec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    rec_t tbl[6];

    osecpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    osecpu_run_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Start a run from IDLE/FIN and play the core model until busy drops.
    task automatic do_run(input rec_t r, input string tag, output int exit_k);
        int   lat;
        logic h;
        exit_k      = 0;
        bus.start   = 1'b1;
        bus.stop    = 1'b0;
        bus.cpu_cr  = HLT_MASK;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_rst_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_rst_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        chk({tag, "_rst_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_rst_timeout"}, 32'(bus.timeout), 32'd0);
        chk({tag, "_rst_cycles"}, bus.cycles, 32'd0);
        lat = 0;
        while (bus.cpu_reset === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rst_latency"}, 32'(lat), 32'(RESET_CYCLES));
        for (int k = 1; k <= RUN_LIMIT; k++) begin
            h           = (r.halt_after >= 0) && (k > r.halt_after);
            bus.cpu_cr  = h ? HLT_MASK : ~HLT_MASK;
            bus.cpu_dr  = h ? r.dr : 32'(k);
            bus.cpu_pc  = h ? r.pc : 16'(k);
            bus.stop    = (k == r.stop_at);
            bus.start   = (k == r.start_at);
            @(negedge clk);
            if (!bus.busy) begin
                exit_k = k;
                break;
            end
        end
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.cpu_cr = 8'h00;
    endtask

    task automatic check_rec(input rec_t r, input string tag, input int exit_k);
        chk({tag, "_exit_cycle"}, 32'(exit_k), 32'(r.exp_exit));
        chk({tag, "_done"}, 32'(bus.done), 32'(r.exp_done));
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'(r.exp_timeout));
        chk({tag, "_result"}, bus.result, r.exp_result);
        chk({tag, "_halt_pc"}, 32'(bus.halt_pc), 32'(r.exp_pc));
        chk({tag, "_cycles"}, bus.cycles, r.exp_cycles);
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    endtask

    initial begin
        int   exit_k;
        int   lat;
        rec_t r;
        checks   = 0;
        failures = 0;

        tbl[0] = '{37, 0, 0, 32'hFFFF_FFFC, 16'h0123, 38, 1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0123, 32'd37};
        tbl[1] = '{999, 0, 0, 32'h1234_5678, 16'hBEEF, 1000, 1'b1, 1'b0, 32'h1234_5678, 16'hBEEF, 32'd999};
`ifdef RUNCTRL_WDT_EN
        tbl[2] = '{-1, 0, 0, 32'h0, 16'h0, 1000, 1'b0, 1'b1, 32'h0000_03E8, 16'h03E8, 32'd999};
`else
        tbl[2] = '{-1, 5000, 0, 32'h0, 16'h0, 5000, 1'b0, 1'b0, 32'h1234_5678, 16'hBEEF, 32'd4999};
`endif
        tbl[3] = '{-1, 10, 5, 32'h0, 16'h0, 10, 1'b0, 1'b0, PREV_R, PREV_P, 32'd9};
        tbl[4] = '{4, 5, 0, 32'hDEAD_BEEF, 16'h5555, 5, 1'b0, 1'b0, PREV_R, PREV_P, 32'd4};
        tbl[5] = '{0, 0, 0, 32'h7FFF_FFFF, 16'hFFFF, 1, 1'b1, 1'b0, 32'h7FFF_FFFF, 16'hFFFF, 32'd0};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.cpu_cr = 8'h00;
        bus.cpu_dr = 32'h0;
        bus.cpu_pc = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("por_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("por_busy", 32'(bus.busy), 32'd0);
        chk("por_done", 32'(bus.done), 32'd0);
        chk("por_timeout", 32'(bus.timeout), 32'd0);
        chk("por_result", bus.result, 32'd0);
        chk("por_halt_pc", 32'(bus.halt_pc), 32'd0);
        chk("por_cycles", bus.cycles, 32'd0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_run(tbl[i], $sformatf("rec%0d", i), exit_k);
            check_rec(tbl[i], $sformatf("rec%0d", i), exit_k);
            @(negedge clk);
        end

        // stop in FIN clears the status flags but keeps the captured result
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("fin_stop_done", 32'(bus.done), 32'd0);
        chk("fin_stop_busy", 32'(bus.busy), 32'd0);
        chk("fin_stop_result", bus.result, 32'h7FFF_FFFF);
        chk("fin_stop_cpu_reset", 32'(bus.cpu_reset), 32'd1);

        // stop during RST aborts back to IDLE
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("rst_stop_busy", 32'(bus.busy), 32'd0);
        repeat (RESET_CYCLES + 2) @(negedge clk);
        chk("rst_stop_idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_stop_idle_busy", 32'(bus.busy), 32'd0);

        // async reset 20 cycles into a run
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (bus.cpu_reset === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ar_latency", 32'(lat), 32'(RESET_CYCLES));
        bus.cpu_cr = 8'h00;
        repeat (19) @(negedge clk);
        chk("ar_cycles_before", bus.cycles, 32'd19);
        #2 reset = 1'b1;
        #1;
        chk("ar_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.done), 32'd0);
        chk("ar_timeout", 32'(bus.timeout), 32'd0);
        chk("ar_result", bus.result, 32'd0);
        chk("ar_halt_pc", 32'(bus.halt_pc), 32'd0);
        chk("ar_cycles", bus.cycles, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        r = '{20, 0, 0, 32'hA5A5_A5A5, 16'h0042, 21, 1'b1, 1'b0, 32'hA5A5_A5A5, 16'h0042, 32'd20};
        do_run(r, "after_ar", exit_k);
        check_rec(r, "after_ar", exit_k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1);
    end
endmodule
